// File: rtl/btn_event_decoder_if.sv
// Bus between the button event decoder and its consumer: the debounced level in,
// single-cycle event pulses and the last press length out.
interface btn_event_decoder_if #(
  parameter int LEN_W = 16
);
  // No handshake. db is a level sampled on every clk edge. Each *_p output is
  // high for exactly one clk cycle per event and must be consumed in that cycle.
  // press_len is a plain register, valid at any time.
  logic             db;
  logic             press_p;
  logic             rel_p;
  logic             short_p;
  logic             long_p;
  logic             dbl_p;
  logic [LEN_W-1:0] press_len;

  modport master (
    output db,
    input  press_p, rel_p, short_p, long_p, dbl_p, press_len
  );

  modport slave (
    input  db,
    output press_p, rel_p, short_p, long_p, dbl_p, press_len
  );
endinterface

// File: rtl/btn_event_decoder.sv
// Classifies debounced button gestures into short, long and double-click events
// and records the duration of the last completed press in ms ticks.
module btn_event_decoder #(
  parameter int TICK_DIV  = 100000,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int LEN_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  btn_event_decoder_if.slave    bus,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [LEN_W-1:0] LONG_T    = LEN_W'(LONG_MS);
  localparam logic [LEN_W-1:0] DCLICK_T  = LEN_W'(DCLICK_MS);
  localparam logic [LEN_W-1:0] MS_MAX    = '1;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [LEN_W-1:0] ms_cnt;
  logic             db_q;
  logic             rise;
  logic             fall;
  logic             tick;

  assign rise      = bus.db & ~db_q;
  assign fall      = ~bus.db & db_q;
  assign tick      = (presc == PRESC_MAX);
  assign state_dbg = state;

  // db_q resets high so a button already held when reset releases is not a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      presc         <= '0;
      ms_cnt        <= '0;
      db_q          <= 1'b1;
      bus.press_p   <= 1'b0;
      bus.rel_p     <= 1'b0;
      bus.short_p   <= 1'b0;
      bus.long_p    <= 1'b0;
      bus.dbl_p     <= 1'b0;
      bus.press_len <= '0;
    end else begin
      db_q        <= bus.db;
      presc       <= tick ? '0 : presc + 1'b1;
      bus.press_p <= rise;
      bus.rel_p   <= fall;
      bus.short_p <= 1'b0;
      bus.long_p  <= 1'b0;
      bus.dbl_p   <= 1'b0;
      if (tick && (ms_cnt != MS_MAX)) ms_cnt <= ms_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (rise) begin
            state  <= PRESS1;
            ms_cnt <= '0;
          end
        end
        PRESS1: begin
          if (fall) begin
            state         <= GAP;
            ms_cnt        <= '0;
            bus.press_len <= ms_cnt;
          end else if (ms_cnt == LONG_T) begin
            // Keep counting into LONG so press_len covers the whole hold.
            state      <= LONG;
            bus.long_p <= 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            state         <= IDLE;
            ms_cnt        <= '0;
            bus.press_len <= ms_cnt;
          end
        end
        GAP: begin
          if (rise) begin
            state     <= PRESS2;
            ms_cnt    <= '0;
            bus.dbl_p <= 1'b1;
          end else if (ms_cnt == DCLICK_T) begin
            state       <= IDLE;
            ms_cnt      <= '0;
            bus.short_p <= 1'b1;
          end
        end
        PRESS2: begin
          if (fall) begin
            state         <= IDLE;
            ms_cnt        <= '0;
            bus.press_len <= ms_cnt;
          end
        end
        default: begin
          state  <= IDLE;
          ms_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with a scoreboard of expected event pulses
// (kind plus a cycle window, or a press_len window for releases).
module tb_btn_event_decoder;

  localparam int LEN_W = 16;
  localparam int W     = 35;

  localparam logic [2:0] K_PRESS = 3'd0;
  localparam logic [2:0] K_DBL   = 3'd1;
  localparam logic [2:0] K_REL   = 3'd2;
  localparam logic [2:0] K_LONG  = 3'd3;
  localparam logic [2:0] K_SHORT = 3'd4;

  localparam logic [31:0] S_IDLE   = 32'd0;
  localparam logic [31:0] S_PRESS1 = 32'd1;
  localparam logic [31:0] S_GAP    = 32'd3;
  localparam logic [31:0] S_PRESS2 = 32'd4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state_dbg;
  int         cyc = 0;
  int         since_rst = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Mirrors the free-running 1 ms prescaler phase (TICK_DIV = 4).
  always @(posedge clk or negedge rst) begin
    if (!rst) since_rst <= 0;
    else      since_rst <= since_rst + 1;
  end

  btn_event_decoder_if #(.LEN_W(LEN_W)) bus ();

  btn_event_decoder #(
    .TICK_DIV (4),
    .LONG_MS  (10),
    .DCLICK_MS(5),
    .LEN_W    (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_PRESS: return "press";
      K_DBL:   return "dbl";
      K_REL:   return "rel";
      K_LONG:  return "long";
      K_SHORT: return "short";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [2:0] k, input int lo, input int hi);
    exp_q.push_back({k, lo[15:0], hi[15:0]});
  endtask

  task automatic consume(input logic [2:0] k, input int t);
    logic [W-1:0] e;
    int v;
    int lo;
    int hi;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: pulse at cycle %0d, expected none", kname(k), t);
    end else begin
      e  = exp_q.pop_front();
      lo = int'(e[31:16]);
      hi = int'(e[15:0]);
      v  = (k == K_REL) ? int'(bus.press_len) : t;
      if ((e[34:32] != k) || (v < lo) || (v > hi)) begin
        failures++;
        $display("FAIL event_%s: got %s value %0d, expected %s in %0d..%0d",
                 kname(e[34:32]), kname(k), v, kname(e[34:32]), lo, hi);
      end
    end
  endtask

  // Monitor: pulses sampled on the falling edge; same-cycle pulses in fixed order.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.press_p) consume(K_PRESS, cyc);
      if (bus.dbl_p)   consume(K_DBL,   cyc);
      if (bus.rel_p)   consume(K_REL,   cyc);
      if (bus.long_p)  consume(K_LONG,  cyc);
      if (bus.short_p) consume(K_SHORT, cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_db(input logic v, output int t);
    @(posedge clk);
    #1;
    bus.db = v;
    t = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int got;
    got = 0;
    while (got < n) begin
      @(posedge clk);
      #1;
      if (since_rst % 4 == 0) got++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_pulses"}, {27'd0, bus.press_p, bus.rel_p, bus.short_p, bus.long_p, bus.dbl_p}, 32'd0);
    check({name, "_len"}, {16'd0, bus.press_len}, 32'd0);
    check({name, "_state"}, {29'd0, state_dbg}, S_IDLE);
  endtask

  task automatic rst_pulse(input string name);
    rst = 1'b0;
    #1;
    check_reset_outputs(name);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    bus.db = 1'b1;
    rst    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // 1: button held through reset release gives no press
    repeat (100) @(posedge clk);
    #1;
    check("held_len", {16'd0, bus.press_len}, 32'd0);
    check("held_state", {29'd0, state_dbg}, S_IDLE);
    set_db(1'b0, t);
    push(K_REL, 0, 0);
    repeat (10) @(posedge clk);

    // 2: short press
    set_db(1'b1, t);
    push(K_PRESS, t + 1, t + 1);
    hold(20);
    set_db(1'b0, t);
    push(K_REL, 4, 5);
    push(K_SHORT, t + 19, t + 22);
    repeat (40) @(posedge clk);

    // 3: long press
    set_db(1'b1, t);
    push(K_PRESS, t + 1, t + 1);
    push(K_LONG, t + 39, t + 42);
    hold(60);
    set_db(1'b0, t);
    push(K_REL, 14, 15);
    repeat (40) @(posedge clk);

    // 4: double click
    set_db(1'b1, t);
    push(K_PRESS, t + 1, t + 1);
    hold(12);
    set_db(1'b0, t);
    push(K_REL, 2, 3);
    hold(8);
    set_db(1'b1, t);
    push(K_PRESS, t + 1, t + 1);
    push(K_DBL, t + 1, t + 1);
    hold(12);
    set_db(1'b0, t);
    push(K_REL, 2, 3);
    repeat (40) @(posedge clk);

    // 5a: release on the exact cycle the long threshold is evaluated
    set_db(1'b1, t);
    push(K_PRESS, t + 1, t + 1);
    @(posedge clk);
    wait_ticks(10);
    bus.db = 1'b0;
    push(K_REL, 10, 10);
    @(posedge clk);
    #1;
    check("tie_fall_state", {29'd0, state_dbg}, S_GAP);
    // 5b: re-press on the exact cycle the double-click window times out
    wait_ticks(5);
    bus.db = 1'b1;
    t = cyc;
    push(K_PRESS, t + 1, t + 1);
    push(K_DBL, t + 1, t + 1);
    @(posedge clk);
    #1;
    check("tie_rise_state", {29'd0, state_dbg}, S_PRESS2);
    repeat (6) @(posedge clk);
    set_db(1'b0, t);
    push(K_REL, 1, 2);
    repeat (40) @(posedge clk);

    // 6a: reset during PRESS1
    set_db(1'b1, t);
    push(K_PRESS, t + 1, t + 1);
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst1_state", {29'd0, state_dbg}, S_PRESS1);
    rst_pulse("rst_press1");
    set_db(1'b0, t);
    push(K_REL, 0, 0);
    repeat (40) @(posedge clk);

    // 6b: reset during GAP; db low with db_q reset high reads as a release
    set_db(1'b1, t);
    push(K_PRESS, t + 1, t + 1);
    hold(8);
    set_db(1'b0, t);
    push(K_REL, 1, 2);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst2_state", {29'd0, state_dbg}, S_GAP);
    push(K_REL, 0, 0);
    rst_pulse("rst_gap");
    repeat (40) @(posedge clk);

    #1;
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
